// File: rtl/seq_pattern_tx.sv
// Serial pattern burst transmitter: sends a captured pattern MSB-first repeat_cnt+1 times.
// Optional zero-gap insertion between patterns is compiled in with SEQ_TX_GAP_EN.
module seq_pattern_tx #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SEQ_TX_GAP_EN
    GAP   = 2'd2,
`endif
    DONE  = 2'd3
  } state_e;

  state_e             state_q;
  logic [PAT_W-1:0]   pat_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   rep_cnt_q;
  logic               out_bit_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               done_q;
`ifdef SEQ_TX_GAP_EN
  logic [GAP_W-1:0]   gap_len_q;
  logic [GAP_W-1:0]   gap_cnt_q;
`else
  logic               unused_gap;
  assign unused_gap = ^gap_len;
`endif

  // bit_cnt_q holds the index of the bit currently on out_bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_TX_GAP_EN
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          out_bit_q   <= 1'b0;
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          if (start) begin
            state_q     <= SHIFT;
            pat_q       <= pattern;
            rep_cnt_q   <= repeat_cnt;
            bit_cnt_q   <= BIT_TOP;
            out_bit_q   <= pattern[PAT_W-1];
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef SEQ_TX_GAP_EN
            gap_len_q   <= gap_len;
`endif
          end
        end

        SHIFT: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
            out_bit_q <= pat_q[bit_cnt_q - BIT_W'(1)];
          end else if (rep_cnt_q == '0) begin
            state_q     <= DONE;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q - CNT_W'(1);
`ifdef SEQ_TX_GAP_EN
            if (gap_len_q != '0) begin
              state_q   <= GAP;
              out_bit_q <= 1'b0;
              gap_cnt_q <= gap_len_q - GAP_W'(1);
            end else
`endif
            begin
              bit_cnt_q <= BIT_TOP;
              out_bit_q <= pat_q[PAT_W-1];
            end
          end
        end

`ifdef SEQ_TX_GAP_EN
        // gap_cnt_q counts gap cycles still to follow the current one
        GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end else begin
            state_q   <= SHIFT;
            bit_cnt_q <= BIT_TOP;
            out_bit_q <= pat_q[PAT_W-1];
          end
        end
`endif

        DONE: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_bit_q   <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_bit_q   <= 1'b0;
        end
      endcase
    end
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx; expected bit stream queued at stimulus time.
// Honors SEQ_TX_GAP_EN the same way the design does.
module tb_seq_pattern_tx;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP_W = 3;
`ifdef SEQ_TX_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  int n_vec = 0;
  int n_err = 0;
  int valid_seen = 0;
  bit mon_en = 1'b0;
  bit exp_q[$];

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .gap_len(gap_len), .out_bit(out_bit),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard sink: every valid cycle pops one expected bit
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        valid_seen++;
        if (exp_q.size() == 0) check_eq("unexp_valid", 32'(out_valid), 32'd0);
        else                   check_eq("out_bit", 32'(out_bit), 32'(exp_q.pop_front()));
      end else begin
        check_eq("idle_bit", 32'(out_bit), 32'd0);
      end
      if (done === 1'b1) check_eq("done_q_empty", 32'(exp_q.size()), 32'd0);
    end
  end

  task automatic push_burst(input logic [PAT_W-1:0] pat, input int r, input int g);
    for (int p = 0; p <= r; p++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(pat[b]);
      if (GAP_ON && p < r)
        for (int k = 0; k < g; k++) exp_q.push_back(1'b0);
    end
  endtask

  // First call edge is the start-capture edge; i counts cycles after it.
  task automatic wait_done(input string tag, input int exp_lat, input bit hold);
    int  i;
    bit  seen;
    seen = 1'b0;
    @(posedge clk); #1;
    pattern = '0;
    if (!hold) begin
      start      = 1'b0;
      repeat_cnt = '1;
      gap_len    = '1;
    end
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    for (i = 1; i <= exp_lat + 10; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_done_lat"}, 32'(i), 32'(exp_lat));
    check_eq({tag, "_valid_cnt"}, 32'(valid_seen), 32'(exp_lat - 1));
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic run_burst(input string tag, input logic [PAT_W-1:0] pat, input int r, input int g);
    int len;
    len = (r + 1) * PAT_W + r * (GAP_ON ? g : 0);
    @(negedge clk);
    pattern    = pat;
    repeat_cnt = CNT_W'(r);
    gap_len    = GAP_W'(g);
    start      = 1'b1;
    valid_seen = 0;
    push_burst(pat, r, g);
    wait_done(tag, len + 1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pattern = '0; repeat_cnt = '0; gap_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_bit", 32'(out_bit), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    run_burst("single", 4'b1011, 0, 0);
    run_burst("rep2_nogap", 4'b1011, 2, 0);
    run_burst("rep1_gap2", 4'b1011, 1, 2);
    run_burst("rep1_gap1", 4'b1100, 1, 1);
    run_burst("max_rep_gap", 4'b1001, 15, 7);
    run_burst("max_rep_nogap", 4'b0110, 15, 0);

    // start held high across DONE; second burst captures the changed pattern
    @(negedge clk);
    pattern = 4'b1011; repeat_cnt = '0; gap_len = '0; start = 1'b1;
    valid_seen = 0;
    push_burst(4'b1011, 0, 0);
    wait_done("hold1", 5, 1'b1);
    push_burst(4'b0000, 0, 0);
    valid_seen = 0;
    wait_done("hold2", 5, 1'b0);

    // reset sampled two edges after the start edge aborts the burst
    @(negedge clk);
    pattern = 4'b1011; repeat_cnt = 4'd3; gap_len = 3'd1; start = 1'b1;
    push_burst(4'b1011, 3, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      check_eq("abort_valid", 32'(out_valid), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end

    // reset wins over start on the same edge
    @(negedge clk);
    reset = 1'b1; start = 1'b1; pattern = 4'b1111;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check_eq("rst_start_busy", 32'(busy), 32'd0);
    check_eq("rst_start_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("rst_start_busy2", 32'(busy), 32'd0);

    for (int t = 0; t < 5; t++) begin
      run_burst("rand", PAT_W'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
